// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: UART receive framing controller.
// Detects a start bit on the synchronized rx line and samples each data bit
// at the centre of its bit period. It emits a one-cycle shift strobe per data
// bit (LSB first) and reports the frame outcome as a one-cycle pulse.
//
// Optional feature: define UART_PARITY_EN to compile in an even-parity bit
// between the data bits and the stop bit. This also adds the parity_err port.
// With the macro undefined, frames are start + DATA_BITS + stop.
//
// CLKS_PER_BIT must be even and >= 4; DATA_BITS must be 1..16.
module uart_frame_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic enable,
    output logic shift_en,
    output logic shift_bit,
    output logic frame_done,
    output logic frame_err,
    output logic busy
`ifdef UART_PARITY_EN
    ,
    output logic parity_err
`endif
);

    // Counter spans 0..CLKS_PER_BIT-1; the index spans 0..DATA_BITS.
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    // Synchronizer stages; rx_s is the only view of the line the FSM uses.
    logic rx_p0;
    logic rx_s;

`ifdef UART_PARITY_EN
    // par_acc is the running XOR of the data bits received so far.
    // par_bad records a parity failure, so frame_done is withheld for the frame.
    logic par_acc;
    logic par_bad;
`endif

    // Two-flop synchronizer for the asynchronous rx line, preset to the idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // Frame FSM: bit timing, data sampling and registered status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift_en   <= 1'b0;
            shift_bit  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle. shift_bit is intentionally not
            // cleared, so it holds the last sampled bit between strobes.
            shift_en   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // enable only gates the start of a frame; dropping it
                    // later has no effect on a frame already in progress.
                    if (enable && !rx_s) begin
                        state <= START;
                        idx   <= '0;
                        busy  <= 1'b1;
`ifdef UART_PARITY_EN
                        par_acc <= 1'b0;
                        par_bad <= 1'b0;
`endif
                    end
                end

                START: begin
                    // Re-check the line half a bit in, to reject short glitches.
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    // Starting half a bit in, sampling every full bit period
                    // lands on the centre of each data bit.
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        shift_en  <= 1'b1;
                        shift_bit <= rx_s;
                        idx       <= idx + IDX_ONE;
`ifdef UART_PARITY_EN
                        par_acc   <= par_acc ^ rx_s;
`endif
                        if (idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

`ifdef UART_PARITY_EN
                PARITY: begin
                    // Even parity: data bits XOR parity bit must be zero.
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= STOP;
                        if (par_acc ^ rx_s) begin
                            parity_err <= 1'b1;
                            par_bad    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`endif

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_PARITY_EN
                            frame_done <= !par_bad;
`else
                            frame_done <= 1'b1;
`endif
                        end else begin
                            // Framing error. The line is still low, so the
                            // FSM must not treat it as a new start bit.
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                WAIT_HIGH: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed and randomized frame stimulus for uart_frame_ctrl.
// Expected shift timing, bit order and frame outcome come from UART framing
// rules. Build with UART_PARITY_EN defined to exercise the parity bit.
module tb_uart_frame_ctrl;

    localparam int C  = 16;
    localparam int DB = 8;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rx     = 1'b1;
    logic enable = 1'b0;
    logic shift_en, shift_bit, frame_done, frame_err, busy;
`ifdef UART_PARITY_EN
    logic parity_err;
`endif

    uart_frame_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .enable     (enable),
        .shift_en   (shift_en),
        .shift_bit  (shift_bit),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Cycle count and a passive record of every DUT strobe
    int cyc       = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int perr_cnt  = 0;
    int busy_cnt  = 0;
    int multi_cnt = 0;
    int   sh_cyc[$];
    logic sh_bit[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (shift_en === 1'b1) begin
            sh_cyc.push_back(cyc);
            sh_bit.push_back(shift_bit);
        end
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
`ifdef UART_PARITY_EN
        if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
        if ((int'(frame_done === 1'b1) + int'(frame_err === 1'b1) + int'(parity_err === 1'b1)) > 1)
            multi_cnt <= multi_cnt + 1;
`else
        if (frame_done === 1'b1 && frame_err === 1'b1) multi_cnt <= multi_cnt + 1;
`endif
    end

    int n_checks = 0;
    int n_fail   = 0;
    int s_sh, s_done, s_err, s_perr, s_busy;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_sh   = sh_cyc.size();
        s_done = done_cnt;
        s_err  = err_cnt;
        s_perr = perr_cnt;
        s_busy = busy_cnt;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (C) @(negedge clk);
    endtask

    // Serialize one frame LSB first. A bad parity bit is sent when par_flip
    // is set. The line is left at the stop-bit level when the task returns.
    task automatic send_frame(input logic [15:0] data, input logic stop_bit,
                              input logic par_flip, input logic drop_en, output int t0);
        @(negedge clk);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) begin
            if (drop_en && i == 1) enable = 1'b0;
            drive_bit(data[i]);
        end
        if (PB != 0) drive_bit((^data[DB-1:0]) ^ par_flip);
        drive_bit(stop_bit);
    endtask

    // Compare the strobes recorded since the last snap() with the ideal
    // receiver. The first sample comes 2 synchronizer cycles plus the first
    // IDLE edge plus 1.5 bit periods after the line falls. Later samples
    // follow every full bit period.
    task automatic check_frame(input string tag, input int t0, input logic [15:0] data,
                               input int e_done, input int e_err, input int e_perr,
                               input logic e_busy);
        int n;
        logic [31:0] word;
        n = sh_cyc.size() - s_sh;
        chkn($sformatf("%s shift count", tag), n, DB);
        if (n > 0)
            chkn($sformatf("%s first shift latency", tag), sh_cyc[s_sh] - t0, 3 + C / 2 + C);
        word = '0;
        for (int i = 0; i < n && i < DB; i++) begin
            word[i] = sh_bit[s_sh + i];
            if (i > 0)
                chkn($sformatf("%s shift spacing %0d", tag, i),
                     sh_cyc[s_sh + i] - sh_cyc[s_sh + i - 1], C);
        end
        chkn($sformatf("%s data bits", tag), word, 32'(data[DB-1:0]));
        chkn($sformatf("%s frame_done pulses", tag), done_cnt - s_done, e_done);
        chkn($sformatf("%s frame_err pulses", tag), err_cnt - s_err, e_err);
        chkn($sformatf("%s parity_err pulses", tag), perr_cnt - s_perr, e_perr);
        chk1($sformatf("%s busy after frame", tag), busy, e_busy);
        chk1($sformatf("%s shift_bit hold", tag), shift_bit, data[DB-1]);
    endtask

    initial begin
        int t0;
        int gap;
        logic [15:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        chk1("reset shift_en", shift_en, 1'b0);
        chk1("reset shift_bit", shift_bit, 1'b0);
        chk1("reset frame_done", frame_done, 1'b0);
        chk1("reset frame_err", frame_err, 1'b0);
        chk1("reset busy", busy, 1'b0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        chk1("idle busy", busy, 1'b0);

        // Good frame 0xA5: bits 1,0,1,0,0,1,0,1
        snap();
        send_frame(16'h00A5, 1'b1, 1'b0, 1'b0, t0);
        repeat (4) @(negedge clk);
        check_frame("a5", t0, 16'h00A5, 1, 0, 0, 1'b0);

        // Random good frames with random idle gaps
        for (int k = 0; k < 6; k++) begin
            d   = 16'($urandom_range(0, (1 << DB) - 1));
            gap = int'($urandom_range(1, 20));
            repeat (gap) @(negedge clk);
            snap();
            send_frame(d, 1'b1, 1'b0, 1'b0, t0);
            repeat (4) @(negedge clk);
            check_frame($sformatf("rand%0d", k), t0, d, 1, 0, 0, 1'b0);
        end

        // 4-cycle glitch: START is entered for half a bit, then abandoned
        repeat (5) @(negedge clk);
        snap();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (C + 8) @(negedge clk);
        chkn("glitch shifts", sh_cyc.size() - s_sh, 0);
        chkn("glitch frame_done", done_cnt - s_done, 0);
        chkn("glitch frame_err", err_cnt - s_err, 0);
        chkn("glitch busy cycles", busy_cnt - s_busy, C / 2);
        chk1("glitch busy after", busy, 1'b0);

        // Bad stop bit on 0x3C, line held low 40 more cycles, then 0x01
        snap();
        send_frame(16'h003C, 1'b0, 1'b0, 1'b0, t0);
        repeat (40) @(negedge clk);
        check_frame("3c bad stop", t0, 16'h003C, 0, 1, 0, 1'b1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk1("wait_high released", busy, 1'b0);
        snap();
        send_frame(16'h0001, 1'b1, 1'b0, 1'b0, t0);
        repeat (4) @(negedge clk);
        check_frame("01 after err", t0, 16'h0001, 1, 0, 0, 1'b0);

        // Reset in the middle of the 4th data bit of 0xFF
        repeat (4) @(negedge clk);
        snap();
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (C / 2) @(negedge clk);
        chk1("pre-reset busy", busy, 1'b1);
        chk1("pre-reset shift_bit", shift_bit, 1'b1);
        chkn("pre-reset shifts", sh_cyc.size() - s_sh, 3);
        rst_n = 1'b0;
        #1;
        chk1("mid reset shift_en", shift_en, 1'b0);
        chk1("mid reset shift_bit", shift_bit, 1'b0);
        chk1("mid reset frame_done", frame_done, 1'b0);
        chk1("mid reset frame_err", frame_err, 1'b0);
        chk1("mid reset busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chkn("aborted frame_done", done_cnt - s_done, 0);
        chkn("aborted frame_err", err_cnt - s_err, 0);
        snap();
        send_frame(16'h00FF, 1'b1, 1'b0, 1'b0, t0);
        repeat (4) @(negedge clk);
        check_frame("ff after reset", t0, 16'h00FF, 1, 0, 0, 1'b0);

        // enable low: frame ignored entirely
        enable = 1'b0;
        snap();
        send_frame(16'h0055, 1'b1, 1'b0, 1'b0, t0);
        repeat (4) @(negedge clk);
        chkn("disabled shifts", sh_cyc.size() - s_sh, 0);
        chkn("disabled busy cycles", busy_cnt - s_busy, 0);
        chkn("disabled frame_done", done_cnt - s_done, 0);

        // enable dropped during the 2nd data bit: frame still completes
        enable = 1'b1;
        repeat (3) @(negedge clk);
        d = 16'($urandom_range(0, (1 << DB) - 1));
        snap();
        send_frame(d, 1'b1, 1'b0, 1'b1, t0);
        repeat (4) @(negedge clk);
        check_frame("enable dropped", t0, d, 1, 0, 0, 1'b0);
        enable = 1'b1;

`ifdef UART_PARITY_EN
        // 0x07 has three ones: parity bit 0 is wrong, parity bit 1 is right
        repeat (4) @(negedge clk);
        snap();
        send_frame(16'h0007, 1'b1, 1'b1, 1'b0, t0);
        repeat (4) @(negedge clk);
        check_frame("07 parity 0", t0, 16'h0007, 0, 0, 1, 1'b0);
        snap();
        send_frame(16'h0007, 1'b1, 1'b0, 1'b0, t0);
        repeat (4) @(negedge clk);
        check_frame("07 parity 1", t0, 16'h0007, 1, 0, 0, 1'b0);
`endif

        chkn("status pulses overlap", multi_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
